// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: tracks in-flight GPR writes in E/M/W against D-stage sources to
// produce stall and forwarding selects, and runs the HI/LO multiply/divide busy counter.
module hazard_scoreboard #(
    parameter int unsigned MULT_CYC = 5,
    parameter int unsigned DIV_CYC  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rs_D,
    input  logic [4:0] rt_D,
    input  logic       use_rs_D,
    input  logic       use_rt_D,
    input  logic [1:0] tuse_rs_D,
    input  logic [1:0] tuse_rt_D,
    input  logic [4:0] wreg_D,
    input  logic       wen_D,
    input  logic [1:0] tnew_D,
    input  logic       md_D,
    input  logic       md_start_E,
    input  logic       md_div_E,
    output logic       stall,
    output logic [1:0] fwd_rs_D,
    output logic [1:0] fwd_rt_D,
    output logic       md_busy
);

    typedef struct packed {
        logic       valid;
        logic [4:0] rg;
        logic [1:0] tnew;
    } entry_t;

    entry_t     ent_e_q, ent_e_d;
    entry_t     ent_m_q, ent_m_d;
    entry_t     ent_w_q, ent_w_d;
    logic [3:0] md_cnt_q, md_cnt_d;

    logic [2:0] rs_res, rt_res;
    logic       data_stall, md_stall;

    function automatic logic [1:0] dec_sat(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

    // Returns {hazard, fwd_code}; the youngest matching entry hides older ones.
    function automatic logic [2:0] resolve(input entry_t e, input entry_t m, input entry_t w,
                                           input logic use_s, input logic [4:0] s,
                                           input logic [1:0] tuse);
        entry_t     win;
        logic [1:0] code;
        logic       found;
        logic [2:0] r;
        win   = '0;
        code  = 2'd0;
        found = 1'b0;
        r     = 3'b000;
        if (use_s && (s != 5'd0)) begin
            if (e.valid && (e.rg == s)) begin
                win = e; code = 2'd1; found = 1'b1;
            end else if (m.valid && (m.rg == s)) begin
                win = m; code = 2'd2; found = 1'b1;
            end else if (w.valid && (w.rg == s)) begin
                win = w; code = 2'd3; found = 1'b1;
            end
        end
        if (found) begin
            if (win.tnew > tuse) begin
                r[2] = 1'b1;
            end else if (win.tnew == 2'd0) begin
                r[1:0] = code;
            end
        end
        return r;
    endfunction

    assign md_busy = (md_cnt_q != 4'd0);

    always_comb begin
        rs_res     = resolve(ent_e_q, ent_m_q, ent_w_q, use_rs_D, rs_D, tuse_rs_D);
        rt_res     = resolve(ent_e_q, ent_m_q, ent_w_q, use_rt_D, rt_D, tuse_rt_D);
        data_stall = rs_res[2] | rt_res[2];
        md_stall   = md_D && (md_busy || md_start_E);
        stall      = data_stall | md_stall;
        fwd_rs_D   = rs_res[1:0];
        fwd_rt_D   = rt_res[1:0];
    end

    always_comb begin
        ent_w_d       = ent_m_q;
        ent_w_d.tnew  = dec_sat(ent_m_q.tnew);
        ent_m_d       = ent_e_q;
        ent_m_d.tnew  = dec_sat(ent_e_q.tnew);
        ent_e_d       = '0;
        if (!stall) begin
            ent_e_d.valid = wen_D && (wreg_D != 5'd0);
            ent_e_d.rg    = wreg_D;
            ent_e_d.tnew  = tnew_D;
        end
        // A new start always reloads, so the most recent operation wins.
        if (md_start_E) begin
            md_cnt_d = md_div_E ? 4'(DIV_CYC) : 4'(MULT_CYC);
        end else if (md_cnt_q != 4'd0) begin
            md_cnt_d = md_cnt_q - 4'd1;
        end else begin
            md_cnt_d = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ent_e_q  <= '0;
            ent_m_q  <= '0;
            ent_w_q  <= '0;
            md_cnt_q <= 4'd0;
        end else begin
            ent_e_q  <= ent_e_d;
            ent_m_q  <= ent_m_d;
            ent_w_q  <= ent_w_d;
            md_cnt_q <= md_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios with literal expectations, then random
// stimulus checked each cycle against an age-based model of in-flight writes.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rs_D, rt_D, wreg_D;
    logic       use_rs_D, use_rt_D, wen_D, md_D, md_start_E, md_div_E;
    logic [1:0] tuse_rs_D, tuse_rt_D, tnew_D;
    logic       stall, md_busy;
    logic [1:0] fwd_rs_D, fwd_rt_D;

    int errors = 0;
    int checks = 0;

    hazard_scoreboard #(.MULT_CYC(5), .DIV_CYC(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .rs_D      (rs_D),
        .rt_D      (rt_D),
        .use_rs_D  (use_rs_D),
        .use_rt_D  (use_rt_D),
        .tuse_rs_D (tuse_rs_D),
        .tuse_rt_D (tuse_rt_D),
        .wreg_D    (wreg_D),
        .wen_D     (wen_D),
        .tnew_D    (tnew_D),
        .md_D      (md_D),
        .md_start_E(md_start_E),
        .md_div_E  (md_div_E),
        .stall     (stall),
        .fwd_rs_D  (fwd_rs_D),
        .fwd_rt_D  (fwd_rt_D),
        .md_busy   (md_busy)
    );

    always #5 clk = ~clk;

    // Model: what entered E at each age (0 = one cycle ago), with its Tnew at entry.
    logic       hv[3];
    logic [4:0] hr[3];
    int         ht[3];
    int         cyc = 0;
    logic       have_md = 1'b0;
    int         md_s = 0;
    int         md_len = 0;

    initial begin
        for (int a = 0; a < 3; a++) begin
            hv[a] = 1'b0; hr[a] = 5'd0; ht[a] = 0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic src_model(input logic use_s, input logic [4:0] s, input int tuse,
                             output logic hz, output logic [1:0] f);
        logic found;
        int   tn;
        hz = 1'b0; f = 2'd0; found = 1'b0;
        if (use_s && s != 5'd0) begin
            for (int a = 0; a < 3; a++) begin
                if (!found && hv[a] && hr[a] == s) begin
                    found = 1'b1;
                    tn = (ht[a] > a) ? ht[a] - a : 0;
                    if (tn > tuse) hz = 1'b1;
                    else if (tn == 0) f = 2'(a + 1);
                end
            end
        end
    endtask

    task automatic model(output logic st, output logic [1:0] frs, output logic [1:0] frt,
                         output logic busy);
        logic h1, h2;
        src_model(use_rs_D, rs_D, int'(tuse_rs_D), h1, frs);
        src_model(use_rt_D, rt_D, int'(tuse_rt_D), h2, frt);
        busy = have_md && cyc > md_s && cyc <= md_s + md_len;
        st = h1 || h2 || (md_D && (busy || md_start_E));
    endtask

    always @(negedge clk) begin
        logic st, bz;
        logic [1:0] frs, frt;
        if (reset === 1'b0) begin
            model(st, frs, frt, bz);
            chk("m_stall", 32'(stall), 32'(st));
            chk("m_fwd_rs", 32'(fwd_rs_D), 32'(frs));
            chk("m_fwd_rt", 32'(fwd_rt_D), 32'(frt));
            chk("m_md_busy", 32'(md_busy), 32'(bz));
        end
    end

    always @(posedge clk) begin
        logic st, bz;
        logic [1:0] frs, frt;
        model(st, frs, frt, bz);
        if (reset) begin
            for (int a = 0; a < 3; a++) hv[a] = 1'b0;
            have_md = 1'b0;
        end else begin
            for (int a = 2; a > 0; a--) begin
                hv[a] = hv[a-1]; hr[a] = hr[a-1]; ht[a] = ht[a-1];
            end
            hv[0] = !st && wen_D && wreg_D != 5'd0;
            hr[0] = wreg_D;
            ht[0] = int'(tnew_D);
            if (md_start_E) begin
                have_md = 1'b1; md_s = cyc; md_len = md_div_E ? 10 : 5;
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        rs_D = 0; rt_D = 0; use_rs_D = 0; use_rt_D = 0; tuse_rs_D = 0; tuse_rt_D = 0;
        wreg_D = 0; wen_D = 0; tnew_D = 0; md_D = 0; md_start_E = 0; md_div_E = 0;
    endtask

    task automatic drain();
        nop();
        repeat (4) tick();
    endtask

    task automatic writer(input logic [4:0] r, input logic [1:0] tn);
        nop(); wen_D = 1; wreg_D = r; tnew_D = tn;
    endtask

    int ns, nb;

    initial begin
        nop();
        reset = 1;
        repeat (2) tick();
        reset = 0;
        #2;
        chk("rst_stall", 32'(stall), 0);
        chk("rst_fwd", 32'({fwd_rs_D, fwd_rt_D}), 0);
        chk("rst_busy", 32'(md_busy), 0);

        // lw $8 then addu $9,$8,$8
        tick(); writer(8, 2); tick();
        nop(); use_rs_D = 1; use_rt_D = 1; rs_D = 8; rt_D = 8; tuse_rs_D = 1; tuse_rt_D = 1;
        wen_D = 1; wreg_D = 9; tnew_D = 1;
        #2 chk("lw_use_stall", 32'(stall), 1);
        tick(); #2;
        chk("lw_use_release", 32'(stall), 0);
        chk("lw_use_fwd", 32'({fwd_rs_D, fwd_rt_D}), 0);
        drain();

        // ori $8 then beq $8,$0
        writer(8, 1); tick();
        nop(); use_rs_D = 1; use_rt_D = 1; rs_D = 8; rt_D = 0;
        #2 chk("beq_stall", 32'(stall), 1);
        tick(); #2;
        chk("beq_release", 32'(stall), 0);
        chk("beq_fwd_m", 32'(fwd_rs_D), 2);
        drain();

        // two writers of $3; the younger (E) wins
        writer(3, 0); tick(); writer(3, 0); tick();
        nop(); use_rs_D = 1; rs_D = 3;
        #2 chk("young_fwd_e", 32'(fwd_rs_D), 1);
        chk("young_stall", 32'(stall), 0);
        drain();

        // writes to $0 are never tracked
        writer(0, 2); tick();
        nop(); use_rs_D = 1; use_rt_D = 1; rs_D = 0; rt_D = 0;
        #2 chk("r0_stall", 32'(stall), 0);
        chk("r0_fwd", 32'({fwd_rs_D, fwd_rt_D}), 0);
        drain();

        // div then mflo: 11 stall cycles, 10 busy
        nop(); md_start_E = 1; md_div_E = 1; md_D = 1; ns = 0; nb = 0;
        for (int i = 0; i < 14; i++) begin
            #2;
            if (stall) ns++;
            if (md_busy) nb++;
            tick();
            md_start_E = 0;
        end
        chk("div_stall_cycles", 32'(ns), 11);
        chk("div_busy_cycles", 32'(nb), 10);
        nop(); md_start_E = 1; md_D = 1; ns = 0; nb = 0;
        for (int i = 0; i < 10; i++) begin
            #2;
            if (stall) ns++;
            if (md_busy) nb++;
            tick();
            md_start_E = 0;
        end
        chk("mult_stall_cycles", 32'(ns), 6);
        chk("mult_busy_cycles", 32'(nb), 5);
        drain();

        // reset mid-divide with a stalled load-use pending
        writer(8, 2); tick();
        nop(); use_rs_D = 1; rs_D = 8; tuse_rs_D = 1; md_start_E = 1; md_div_E = 1;
        #2 chk("pre_rst_stall", 32'(stall), 1);
        tick(); md_start_E = 0; reset = 1;
        tick(); reset = 0; #2;
        chk("mid_rst_stall", 32'(stall), 0);
        chk("mid_rst_busy", 32'(md_busy), 0);
        chk("mid_rst_fwd", 32'({fwd_rs_D, fwd_rt_D}), 0);
        drain();

        // random traffic over a small register set to provoke matches
        for (int i = 0; i < 3000; i++) begin
            rs_D       = 5'($urandom_range(0, 3));
            rt_D       = 5'($urandom_range(0, 3));
            use_rs_D   = 1'($urandom);
            use_rt_D   = 1'($urandom);
            tuse_rs_D  = 2'($urandom_range(0, 2));
            tuse_rt_D  = 2'($urandom_range(0, 2));
            wreg_D     = 5'($urandom_range(0, 3));
            wen_D      = 1'($urandom);
            tnew_D     = 2'($urandom_range(0, 2));
            md_D       = ($urandom_range(0, 5) == 0);
            md_start_E = ($urandom_range(0, 11) == 0);
            md_div_E   = 1'($urandom);
            reset      = ($urandom_range(0, 199) == 0);
            tick();
        end
        reset = 0;
        nop();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
